subtractor_8bit: RTL and testbench
==================================

Name: subtractor_8bit

Overview:
Registered 8-bit two's-complement subtractor computing result = a - b modulo 256, with status flags. Used as a small arithmetic leaf inside datapaths. Operands are captured with a valid qualifier. Result and flags appear one clock later.

Parameters:
WIDTH, 8, operand/result width in bits; all behaviour below is stated for WIDTH=8.

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
a  input  WIDTH  minuend; unsigned or two's-complement, same bit pattern
b  input  WIDTH  subtrahend
in_valid  input  1  a/b are sampled on this cycle when high
result  output  WIDTH  registered (a - b) mod 2^WIDTH
out_valid  output  1  high for one cycle when result/flags hold a new difference
borrow  output  1  unsigned borrow: 1 when a < b as unsigned
overflow  output  1  signed overflow: a[MSB]!=b[MSB] and result[MSB]!=a[MSB]
zero  output  1  result == 0
negative  output  1  result[MSB]

Behaviour:
- Arithmetic: diff = a + ~b + 1, computed as a WIDTH-bit ripple-borrow chain with borrow-in 0. Result wraps modulo 2^WIDTH; no saturation.
- borrow is the final borrow-out of the chain, equal to NOT the carry-out of a + ~b + 1.
- overflow uses the two's-complement rule above. zero and negative are derived from the difference being registered.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, then after edge N+1's update result/flags reflect those operands and out_valid=1.
- Hold behaviour: when in_valid=0 at an edge, result and flags hold their previous values and out_valid=0. No back-pressure; every valid input produces an output.
- Back-to-back: in_valid high on consecutive cycles gives one output per cycle, in order, at full throughput.
- Reset: while rst=1 at a rising edge, result=0, borrow=0, overflow=0, negative=0, zero=1 (consistent with result=0), out_valid=0.
- rst takes priority over in_valid. An operation captured one cycle before reset asserts is discarded, and no out_valid is produced for it.
- Outputs are only changed at the clock edge, so there are no combinational paths from inputs to outputs.
- Identical operands (e.g. 0x81 - 0x81) give result 0, zero=1, borrow=0, overflow=0.

Decomposition:
- Shared package: WIDTH default constant and a flags struct type {borrow, overflow, zero, negative} reused by other ALU blocks.
- One natural sub-module: full_subtractor (1-bit cell: inputs x, y, bin; outputs d, bout). It is instantiated WIDTH times in a generate chain.
- Top-level logic: output registers, flag derivation, valid pipeline.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and a=0x55, b=0x0F -> result=0x00, zero=1, out_valid=0. Release rst -> next output is 0x46 (70), out_valid=1.
- Basic stream, in_valid high every cycle -> one-cycle-delayed results with all flags 0 and out_valid high continuously:
  - 3-1 -> 2
  - 0x4C-0x15 -> 0x37 (55)
  - 0x71-0x39 -> 0x38 (56)
  - 0x61-0x21 -> 0x40 (64)
- Equal operands and negative result:
  - 0x81-0x81 -> 0x00, zero=1.
  - 0xF8-0x02 -> 0xF6, negative=1, borrow=0, overflow=0.
  - 0xC6-0x85 -> 0x41 (65), borrow=0.
- Flag boundaries:
  - 0x01-0x02 -> 0xFF, borrow=1, negative=1, overflow=0.
  - 0x80-0x01 -> 0x7F, overflow=1, borrow=0.
  - 0x7F-0xFF -> 0x80, overflow=1, borrow=1.
- Hold and reset mid-operation:
  - Drop in_valid for 3 cycles -> result/flags hold last value, out_valid=0.
  - Assert rst on the cycle after in_valid=1 (a=0x0E, b=0x07) -> result stays 0, out_valid stays 0.
- Random: 10k random a/b pairs with random in_valid. A scoreboard compares result, borrow, overflow, zero and negative against a golden 9-bit subtraction model at 1-cycle latency.

Source files
------------

// File: rtl/subtractor_8bit_pkg.sv
// Shared types for the small ALU leaves: default datapath width and the
// arithmetic status-flag bundle.
package subtractor_8bit_pkg;

    localparam int SUB_WIDTH = 8;

    typedef struct packed {
        logic borrow;
        logic overflow;
        logic zero;
        logic negative;
    } sub_flags_t;

    // Flag value matching a cleared (all-zero) result.
    localparam sub_flags_t SUB_FLAGS_RST = '{borrow: 1'b0, overflow: 1'b0, zero: 1'b1, negative: 1'b0};

endpackage

// File: rtl/subtractor_8bit_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout set when the bit
// position needs to borrow from the next higher one.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/subtractor_8bit.sv
// Registered a - b with borrow/overflow/zero/negative flags. Operands are
// captured on in_valid; the difference and flags appear one cycle later.
module subtractor_8bit
    import subtractor_8bit_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] result_q, result_d;
    sub_flags_t       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   bchain;

    // Ripple-borrow chain over the captured operands, borrow-in tied low.
    assign bchain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_subtractor u_fs (
            .x   (a_q[i]),
            .y   (b_q[i]),
            .bin (bchain[i]),
            .d   (diff[i]),
            .bout(bchain[i+1])
        );
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block can infer a latch.
        a_d         = a_q;
        b_d         = b_q;
        vld_d       = in_valid;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = vld_q;

        if (in_valid) begin
            a_d = a;
            b_d = b;
        end

        if (vld_q) begin
            result_d          = diff;
            flags_d.borrow    = bchain[WIDTH];
            flags_d.overflow  = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            flags_d.zero      = (diff == '0);
            flags_d.negative  = diff[MSB];
        end
    end

    // NOTE: reset clears the capture stage too, so an operand taken just before rst never emerges.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            vld_q       <= 1'b0;
            result_q    <= '0;
            flags_q     <= SUB_FLAGS_RST;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            vld_q       <= vld_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign borrow    = flags_q.borrow;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule

// File: tb/tb_subtractor_8bit.sv
// Scoreboard bench for subtractor_8bit: directed vectors with hand-derived
// expectations, then random traffic checked against a 9-bit subtraction model.
module tb_subtractor_8bit;

    typedef struct {
        logic [7:0] result;
        logic       borrow;
        logic       overflow;
        logic       zero;
        logic       negative;
    } exp_t;

    typedef struct {
        int   cyc;
        exp_t e;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       in_valid;
    logic [7:0] result;
    logic       out_valid, borrow, overflow, zero, negative;

    int n_checks = 0;
    int n_errors = 0;

    sb_entry_t sb_q[$];
    exp_t      drv_exp;
    exp_t      last_exp;
    exp_t      rst_exp;
    int        cyc = 0;
    bit        rst_seen = 1'b0;
    bit        armed = 1'b0;

    subtractor_8bit dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .result   (result),
        .out_valid(out_valid),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic bo, input logic ov,
                                input logic z, input logic n);
        exp_t e;
        e.result   = r;
        e.borrow   = bo;
        e.overflow = ov;
        e.zero     = z;
        e.negative = n;
        return e;
    endfunction

    function automatic exp_t golden(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] full;
        exp_t       e;
        full       = {1'b0, x} - {1'b0, y};
        e.result   = full[7:0];
        e.borrow   = full[8];
        e.overflow = (x[7] != y[7]) && (full[7] != x[7]);
        e.zero     = (full[7:0] == 8'h00);
        e.negative = full[7];
        return e;
    endfunction

    // Stimulus side: record the edge at which each valid operand pair is taken.
    always @(posedge clk) begin
        cyc++;
        rst_seen = rst;
        if (rst) begin
            armed = 1'b1;
            sb_q.delete();
        end else if (in_valid) begin
            sb_entry_t ent;
            ent.cyc = cyc;
            ent.e   = drv_exp;
            sb_q.push_back(ent);
        end
    end

    // Output side: an entry taken at edge N must surface right after edge N+1.
    always @(negedge clk) begin
        if (armed) begin
            bit        exp_v;
            sb_entry_t ent;
            if (rst_seen) last_exp = rst_exp;
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc - 1) begin
                ent = sb_q.pop_front();
            end
            exp_v = (sb_q.size() > 0) && (sb_q[0].cyc == cyc - 1);
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) begin
                ent      = sb_q.pop_front();
                last_exp = ent.e;
            end
            check("result",   {24'd0, result},   {24'd0, last_exp.result});
            check("borrow",   {31'd0, borrow},   {31'd0, last_exp.borrow});
            check("overflow", {31'd0, overflow}, {31'd0, last_exp.overflow});
            check("zero",     {31'd0, zero},     {31'd0, last_exp.zero});
            check("negative", {31'd0, negative}, {31'd0, last_exp.negative});
        end
    end

    task automatic drive(input logic r, input logic v, input logic [7:0] x,
                         input logic [7:0] y, input exp_t e);
        rst      = r;
        in_valid = v;
        a        = x;
        b        = y;
        drv_exp  = e;
        @(negedge clk);
    endtask

    initial begin
        exp_t none;
        none     = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_exp  = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        last_exp = rst_exp;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        drv_exp  = none;
        @(negedge clk);

        // Reset held with valid operands present, then released.
        drive(1'b1, 1'b1, 8'h55, 8'h0F, none);
        drive(1'b1, 1'b1, 8'h55, 8'h0F, none);
        drive(1'b0, 1'b1, 8'h55, 8'h0F, mk(8'h46, 1'b0, 1'b0, 1'b0, 1'b0));

        // Basic back-to-back stream.
        drive(1'b0, 1'b1, 8'h03, 8'h01, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 1'b1, 8'h4C, 8'h15, mk(8'h37, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 1'b1, 8'h71, 8'h39, mk(8'h38, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 1'b1, 8'h61, 8'h21, mk(8'h40, 1'b0, 1'b0, 1'b0, 1'b0));

        // Equal operands and negative results.
        drive(1'b0, 1'b1, 8'h81, 8'h81, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        drive(1'b0, 1'b1, 8'hF8, 8'h02, mk(8'hF6, 1'b0, 1'b0, 1'b0, 1'b1));
        drive(1'b0, 1'b1, 8'hC6, 8'h85, mk(8'h41, 1'b0, 1'b0, 1'b0, 1'b0));

        // Flag boundaries.
        drive(1'b0, 1'b1, 8'h01, 8'h02, mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
        drive(1'b0, 1'b1, 8'h80, 8'h01, mk(8'h7F, 1'b0, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 1'b1, 8'h7F, 8'hFF, mk(8'h80, 1'b1, 1'b1, 1'b0, 1'b1));

        // Hold: in_valid low for three cycles with changing operands.
        drive(1'b0, 1'b0, 8'h12, 8'h34, none);
        drive(1'b0, 1'b0, 8'hAA, 8'h55, none);
        drive(1'b0, 1'b0, 8'h00, 8'hFF, none);

        // Reset on the cycle after a capture discards that operation.
        drive(1'b0, 1'b1, 8'h0E, 8'h07, mk(8'h07, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 1'b0, 8'h00, 8'h00, none);
        drive(1'b0, 1'b0, 8'h00, 8'h00, none);
        drive(1'b0, 1'b0, 8'h00, 8'h00, none);

        // Random traffic against the golden model.
        for (int i = 0; i < 10000; i++) begin
            logic [7:0] ra, rb;
            logic       rv;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rv = ($urandom_range(0, 3) != 0);
            drive(1'b0, rv, ra, rb, golden(ra, rb));
        end

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00, 8'h00, none);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
